// File: rtl/axi2wb.sv
// axi2wb: 64-bit AXI4-Lite slave to 32-bit classic Wishbone master bridge.
// Optional AXI2WB_ERR_EN adds i_wb_err, which terminates a cycle and returns SLVERR.
module axi2wb #(
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready,
    input  logic [31:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [63:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
`ifdef AXI2WB_ERR_EN
    input  logic        i_wb_err,
`endif
    input  logic        i_wb_ack
);
    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, WR_RESP, RD, RD_RESP} state_t;

    state_t      r_state, w_state;
    logic [31:2] r_addr, w_addr;
    logic [63:0] r_data, w_data;
    logic [7:0]  r_strb, w_strb;
    logic        w_wr_hs, w_rd_hs, w_done, w_err, w_arm, w_unused;
    logic        w_awready, w_arready, w_bvalid, w_rvalid, w_cyc, w_we;
    logic [1:0]  w_bresp, w_rresp;
    logic [63:0] w_rdata;
    logic [31:0] w_wb_adr, w_wb_dat;
    logic [3:0]  w_wb_sel;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return BYTE_SWAP ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
    endfunction

    function automatic logic [3:0] swap4(input logic [3:0] s);
        return BYTE_SWAP ? {s[0], s[1], s[2], s[3]} : s;
    endfunction

    assign w_unused = ^{i_awaddr[1:0], i_araddr[1:0]};
`ifdef AXI2WB_ERR_EN
    assign w_err = o_wb_stb & i_wb_err;
`else
    assign w_err = 1'b0;
`endif
    // ack/err only count while a strobe is actually out on the bus
    assign w_done  = o_wb_stb & (i_wb_ack | w_err);
    assign w_wr_hs = o_awready & o_wready & i_awvalid & i_wvalid;
    assign w_rd_hs = o_arready & i_arvalid;
    assign w_addr  = w_wr_hs ? i_awaddr[31:2] : w_rd_hs ? i_araddr[31:2] : r_addr;
    assign w_data  = w_wr_hs ? i_wdata : r_data;
    assign w_strb  = w_wr_hs ? i_wstrb : r_strb;

    always_comb begin
        w_state = r_state;
        case (r_state)
            IDLE:    w_state = w_wr_hs ? (|w_strb[3:0] ? WR_LO : |w_strb[7:4] ? WR_HI : WR_RESP)
                             : w_rd_hs ? RD : IDLE;
            WR_LO:   w_state = !w_done ? WR_LO : (!w_err && |r_strb[7:4]) ? WR_HI : WR_RESP;
            WR_HI:   w_state = w_done ? WR_RESP : WR_HI;
            RD:      w_state = w_done ? RD_RESP : RD;
            WR_RESP: w_state = (o_bvalid & i_bready) ? IDLE : WR_RESP;
            RD_RESP: w_state = (o_rvalid & i_rready) ? IDLE : RD_RESP;
            default: w_state = IDLE;
        endcase
        // readies are armed on entry to IDLE so a new request is taken the cycle after a response
        w_arm     = (w_state == IDLE) && !o_awready && !o_arready;
        w_awready = w_arm & i_awvalid & i_wvalid;
        w_arready = w_arm & i_arvalid & ~(i_awvalid & i_wvalid);
        w_cyc     = w_state inside {WR_LO, WR_HI, RD};
        w_we      = w_state inside {WR_LO, WR_HI};
        w_wb_adr  = w_state == WR_LO ? {w_addr[31:3], 3'b000} :
                    w_state == WR_HI ? {w_addr[31:3], 3'b100} :
                    w_state == RD    ? {w_addr, 2'b00} : o_wb_adr;
        w_wb_dat  = w_state == WR_LO ? swap32(w_data[31:0]) :
                    w_state == WR_HI ? swap32(w_data[63:32]) : o_wb_dat;
        w_wb_sel  = w_state == WR_LO ? swap4(w_strb[3:0]) :
                    w_state == WR_HI ? swap4(w_strb[7:4]) :
                    w_state == RD    ? 4'hF : o_wb_sel;
        w_rdata   = (r_state == RD && w_done) ? (w_err ? 64'd0 : {2{swap32(i_wb_rdt)}}) : o_rdata;
        w_bvalid  = w_state == WR_RESP;
        w_rvalid  = w_state == RD_RESP;
        w_bresp   = !w_bvalid ? 2'b00 : r_state == WR_RESP ? o_bresp : {w_err, 1'b0};
        w_rresp   = !w_rvalid ? 2'b00 : r_state == RD_RESP ? o_rresp : {w_err, 1'b0};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_arready <= 1'b0;
            o_bvalid  <= 1'b0;
            o_bresp   <= 2'b00;
            o_rvalid  <= 1'b0;
            o_rresp   <= 2'b00;
            o_rdata   <= '0;
            o_wb_adr  <= '0;
            o_wb_dat  <= '0;
            o_wb_sel  <= '0;
            o_wb_we   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_addr    <= w_addr;
            r_data    <= w_data;
            r_strb    <= w_strb;
            o_awready <= w_awready;
            o_wready  <= w_awready;
            o_arready <= w_arready;
            o_bvalid  <= w_bvalid;
            o_bresp   <= w_bresp;
            o_rvalid  <= w_rvalid;
            o_rresp   <= w_rresp;
            o_rdata   <= w_rdata;
            o_wb_adr  <= w_wb_adr;
            o_wb_dat  <= w_wb_dat;
            o_wb_sel  <= w_wb_sel;
            o_wb_we   <= w_we;
            o_wb_cyc  <= w_cyc;
            o_wb_stb  <= w_cyc;
        end
    end
endmodule

// File: tb/tb_axi2wb.sv
// tb_axi2wb: random AXI traffic checked every cycle against a transaction-level model,
// with a BYTE_SWAP=1 and a BYTE_SWAP=0 instance in lockstep, plus directed literal checks.
`timescale 1ns/1ps
module tb_axi2wb;
`ifdef AXI2WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic [31:0] i_awaddr = '0, i_araddr = '0, i_wb_rdt = '0;
    logic [63:0] i_wdata = '0;
    logic [7:0]  i_wstrb = '0;
    logic        i_awvalid = 0, i_wvalid = 0, i_bready = 0, i_arvalid = 0, i_rready = 0;
    logic        i_wb_ack = 0, i_wb_err = 0;

    logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_wb_we, o_wb_cyc, o_wb_stb;
    logic [1:0]  o_bresp, o_rresp;
    logic [63:0] o_rdata;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        z_awready, z_wready, z_arready, z_bvalid, z_rvalid, z_wb_we, z_wb_cyc, z_wb_stb;
    logic [1:0]  z_bresp, z_rresp;
    logic [63:0] z_rdata;
    logic [31:0] z_wb_adr, z_wb_dat;
    logic [3:0]  z_wb_sel;

    axi2wb #(.BYTE_SWAP(1'b1)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt),
`ifdef AXI2WB_ERR_EN
        .i_wb_err(i_wb_err),
`endif
        .i_wb_ack(i_wb_ack)
    );

    axi2wb #(.BYTE_SWAP(1'b0)) u_dut0 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(z_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(z_wready),
        .o_bresp(z_bresp), .o_bvalid(z_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(z_arready),
        .o_rdata(z_rdata), .o_rresp(z_rresp), .o_rvalid(z_rvalid), .i_rready(i_rready),
        .o_wb_adr(z_wb_adr), .o_wb_dat(z_wb_dat), .o_wb_sel(z_wb_sel), .o_wb_we(z_wb_we),
        .o_wb_cyc(z_wb_cyc), .o_wb_stb(z_wb_stb), .i_wb_rdt(i_wb_rdt),
`ifdef AXI2WB_ERR_EN
        .i_wb_err(i_wb_err),
`endif
        .i_wb_ack(i_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_fail = 0;
    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] sw32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction
    function automatic logic [3:0] sw4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    // Wishbone slave: ack after ws wait cycles, occasional stray acks with stb low
    int ws = 0, err_pct = 0, noise_pct = 0;
    bit fixed_en = 0;
    logic [31:0] fixed_rdt = '0;
    initial begin
        int cnt = 0;
        forever begin
            @(posedge i_clk);
            #1;
            i_wb_ack = 0;
            i_wb_err = 0;
            if (!o_wb_stb || i_rst) begin
                cnt = 0;
                if (!i_rst && $urandom_range(99) < noise_pct) i_wb_ack = 1;
            end else if (cnt >= ws) begin
                cnt = 0;
                i_wb_rdt = fixed_en ? fixed_rdt : $urandom;
                if (ERR_EN && $urandom_range(99) < err_pct) i_wb_err = 1;
                else i_wb_ack = 1;
            end else cnt++;
        end
    end

    // transaction model: phase 0 idle, 1 wishbone cycles pending, 2 response pending
    typedef struct packed {logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;} wb_t;
    wb_t wbq[$];
    wb_t e;
    int phase = 0, cyc = 0, t_aw = 0, t_ar = 0, t_b = 0, t_bv = 0, t_rv = 0;
    bit rd_txn = 0, prev_rst = 0, pb = 0, pr = 0, pa = 0, pq = 0;
    logic [1:0] e_resp = 0;
    logic [63:0] e_rd1 = 0, e_rd0 = 0;
    logic [31:0] log_adr[$], log_dat[$];
    logic [3:0] log_sel[$];

    always @(negedge i_clk) begin
        cyc++;
        if (prev_rst)
            chk("reset_zero", {o_awready, o_wready, o_arready, o_bvalid, o_bresp, o_rvalid, o_rresp, o_rdata,
                               o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
                               z_wb_cyc, z_wb_stb, z_bvalid, z_rvalid, z_rdata[15:0]}, '0);
        prev_rst = i_rst;
        if (i_rst) begin
            phase = 0;
            wbq.delete();
        end else begin
            chk("wb_cyc_stb", {o_wb_cyc, o_wb_stb, z_wb_cyc, z_wb_stb}, {4{phase == 1}});
            if (phase == 1) begin
                e = wbq[0];
                chk("wb_adr_we", {o_wb_adr, z_wb_adr, o_wb_we, z_wb_we}, {e.adr, e.adr, e.we, e.we});
                if (e.we) chk("wb_dat_sel", {o_wb_dat, o_wb_sel, z_wb_dat, z_wb_sel}, {sw32(e.dat), sw4(e.sel), e.dat, e.sel});
                else chk("wb_rd_sel", {o_wb_sel, z_wb_sel}, 8'hFF);
            end
            chk("valids", {o_bvalid, z_bvalid, o_rvalid, z_rvalid},
                {{2{phase == 2 && !rd_txn}}, {2{phase == 2 && rd_txn}}});
            if (phase == 2 && rd_txn) chk("rresp_rdata", {o_rresp, z_rresp, o_rdata, z_rdata}, {e_resp, e_resp, e_rd1, e_rd0});
            if (phase == 2 && !rd_txn) chk("bresp", {o_bresp, z_bresp}, {e_resp, e_resp});
            chk("ready_rules", {o_awready != o_wready, phase != 0 && (o_awready || o_arready), o_awready && o_arready,
                                {z_awready, z_wready, z_arready} != {o_awready, o_wready, o_arready},
                                o_awready && pa, o_arready && pq}, '0);
            if (o_bvalid && !pb) t_bv = cyc;
            if (o_rvalid && !pr) t_rv = cyc;
            if (o_bvalid && i_bready) t_b = cyc;
            {pb, pr, pa, pq} = {o_bvalid, o_rvalid, o_awready, o_arready};
            case (phase)
                0: if (o_awready && o_wready && i_awvalid && i_wvalid) begin
                    rd_txn = 0;
                    t_aw = cyc;
                    e_resp = 2'b00;
                    if (|i_wstrb[3:0]) wbq.push_back({i_awaddr[31:3], 3'b000, i_wdata[31:0], i_wstrb[3:0], 1'b1});
                    if (|i_wstrb[7:4]) wbq.push_back({i_awaddr[31:3], 3'b100, i_wdata[63:32], i_wstrb[7:4], 1'b1});
                    phase = wbq.size() != 0 ? 1 : 2;
                end else if (o_arready && i_arvalid) begin
                    rd_txn = 1;
                    t_ar = cyc;
                    e_resp = 2'b00;
                    wbq.push_back({i_araddr[31:2], 2'b00, 32'd0, 4'hF, 1'b0});
                    phase = 1;
                end
                1: if (o_wb_stb && (i_wb_ack || i_wb_err)) begin
                    log_adr.push_back(o_wb_adr);
                    log_dat.push_back(o_wb_dat);
                    log_sel.push_back(o_wb_sel);
                    void'(wbq.pop_front());
                    if (i_wb_err) begin
                        wbq.delete();
                        e_resp = 2'b10;
                    end
                    e_rd1 = i_wb_err ? 64'd0 : {2{sw32(i_wb_rdt)}};
                    e_rd0 = i_wb_err ? 64'd0 : {2{i_wb_rdt}};
                    if (wbq.size() == 0) phase = 2;
                end
                default: if (rd_txn ? (o_rvalid && i_rready) : (o_bvalid && i_bready)) phase = 0;
            endcase
        end
    end

    task automatic log_clear();
        log_adr.delete();
        log_dat.delete();
        log_sel.delete();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input int bp,
                             output logic [1:0] br);
        int n = 0;
        @(posedge i_clk);
        #1;
        {i_awaddr, i_wdata, i_wstrb, i_awvalid, i_wvalid} = {a, d, s, 2'b11};
        do begin
            @(negedge i_clk);
            n++;
        end while (!(o_awready && o_wready) && n < 200);
        chk("aw_timeout", n < 200, 1);
        @(posedge i_clk);
        #1;
        {i_awvalid, i_wvalid} = 2'b00;
        n = 0;
        forever begin
            i_bready = $urandom_range(99) < bp;
            @(negedge i_clk);
            if ((o_bvalid && i_bready) || ++n > 300) break;
            @(posedge i_clk);
            #1;
        end
        chk("b_timeout", n <= 300, 1);
        br = o_bresp;
        @(posedge i_clk);
        #1;
        i_bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int bp, input int hold,
                            output logic [63:0] rd1, output logic [63:0] rd0, output logic [1:0] rr);
        int n = 0;
        @(posedge i_clk);
        #1;
        {i_araddr, i_arvalid} = {a, 1'b1};
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_arready && n < 200);
        chk("ar_timeout", n < 200, 1);
        @(posedge i_clk);
        #1;
        i_arvalid = 0;
        n = 0;
        forever begin
            i_rready = hold == 0 && $urandom_range(99) < bp;
            @(negedge i_clk);
            if ((o_rvalid && i_rready) || ++n > 300) break;
            if (o_rvalid && hold > 0) hold--;
            @(posedge i_clk);
            #1;
        end
        chk("r_timeout", n <= 300, 1);
        {rd1, rd0, rr} = {o_rdata, z_rdata, o_rresp};
        @(posedge i_clk);
        #1;
        i_rready = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] br, rr;
        logic [63:0] r1, r0;
        logic [7:0] s;
        int n;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 0;
        ws = 2;
        log_clear();
        axi_write(32'h1000, 64'h11223344_55667788, 8'hFF, 100, br);
        chk("d1_count", log_adr.size(), 2);
        chk("d1_lo", {log_adr[0], log_dat[0], log_sel[0]}, {32'h1000, 32'h88776655, 4'hF});
        chk("d1_hi", {log_adr[1], log_dat[1], log_sel[1]}, {32'h1004, 32'h44332211, 4'hF});
        chk("d1_bresp", br, 2'b00);
        log_clear();
        axi_write(32'h3008, 64'hDEADBEEF_CAFEF00D, 8'h30, 100, br);
        chk("d2_count", log_adr.size(), 1);
        chk("d2_cycle", {log_adr[0], log_dat[0], log_sel[0]}, {32'h300C, 32'hEFBEADDE, 4'hC});
        log_clear();
        axi_write(32'h4000, 64'h1, 8'h00, 100, br);
        chk("d3_no_wb", log_adr.size(), 0);
        chk("d3_latency", t_bv - t_aw, 1);
        ws = 0;
        axi_write(32'h5000, 64'h0123456789ABCDEF, 8'hFF, 100, br);
        chk("d4_latency", t_bv - t_aw, 3);
        fixed_en = 1;
        fixed_rdt = 32'hAABBCCDD;
        log_clear();
        axi_read(32'h2004, 100, 5, r1, r0, rr);
        chk("d5_adr", log_adr[0], 32'h2004);
        chk("d5_rdata_noswap", r0, 64'hAABBCCDD_AABBCCDD);
        chk("d5_rdata_swap", r1, 64'hDDCCBBAA_DDCCBBAA);
        chk("d5_latency", t_rv - t_ar, 2);
        fixed_en = 0;
        ws = 1;
        fork
            axi_write(32'h6000, 64'h5555AAAA_12345678, 8'hFF, 100, br);
            axi_read(32'h7000, 100, 0, r1, r0, rr);
        join
        chk("d6_write_first", t_ar > t_aw, 1);
        chk("d6_read_after_b", t_ar - t_b, 1);
        ws = 5;
        @(posedge i_clk);
        #1;
        {i_awaddr, i_wdata, i_wstrb, i_awvalid, i_wvalid} = {32'h8000, 64'h77, 8'hFF, 2'b11};
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_awready && n < 200);
        @(posedge i_clk);
        #1;
        {i_awvalid, i_wvalid} = 2'b00;
        @(negedge i_clk);
        chk("d7_in_wr_lo", {o_wb_stb, o_wb_we, o_wb_adr}, {2'b11, 32'h8000});
        @(posedge i_clk);
        #1;
        i_rst = 1;
        @(posedge i_clk);
        #1;
        i_rst = 0;
        repeat (3) @(negedge i_clk);
        chk("d7_no_resp", {o_bvalid, o_wb_stb}, 2'b00);
        ws = 1;
        log_clear();
        axi_write(32'h9000, 64'hFFEEDDCC_BBAA9988, 8'h0F, 100, br);
        chk("d7_after_reset", {log_adr.size(), log_adr[0], log_dat[0], br}, {32'd1, 32'h9000, 32'h8899AABB, 2'b00});
`ifdef AXI2WB_ERR_EN
        err_pct = 100;
        log_clear();
        axi_write(32'hA000, 64'h1, 8'hFF, 100, br);
        chk("e1_skip_hi", log_adr.size(), 1);
        chk("e1_bresp", br, 2'b10);
        axi_read(32'hB004, 100, 0, r1, r0, rr);
        chk("e2_read", {rr, r1, r0}, {2'b10, 128'd0});
        err_pct = 15;
`endif
        noise_pct = 10;
        for (int k = 0; k < 200; k++) begin
            ws = $urandom_range(0, 3);
            n = $urandom_range(30, 100);
            if ($urandom_range(1) == 1) begin
                s = 8'($urandom);
                if ($urandom_range(3) == 0) s = 8'h00;
                else if ($urandom_range(3) == 0) s = 8'hFF;
                axi_write($urandom, {$urandom, $urandom}, s, n, br);
            end else axi_read($urandom, n, $urandom_range(0, 2), r1, r0, rr);
        end
        repeat (4) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
